// File: rtl/updown_sequencer.sv
// ---------------------------------------------------------------------------
// updown_sequencer
//
// Purpose:
//   Drives the Enable and Swap inputs of an up/down counter pair from a
//   programmed command. A command gives the number of count steps per round,
//   the number of rounds, and whether each round ends with one Swap cycle.
//   The command is taken over a valid/ready handshake. Hold pauses the
//   sequence. Abort ends it early.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   cmd_valid     in   command present
//   cmd_ready     out  command accepted this cycle if cmd_valid (IDLE only)
//   cmd_steps     in   [STEP_W]  count steps per round
//   cmd_rounds    in   [ROUND_W] number of rounds
//   cmd_swap_end  in   issue one Swap cycle at the end of each round
//   hold          in   pause: no step or swap issued while high
//   abort         in   terminate the active command
//   enable        out  to counter Enable (combinational)
//   swap          out  to counter Swap (combinational)
//   busy          out  sequencer is in RUN or SWAP
//   done          out  one-cycle pulse at command end (registered)
//   aborted       out  valid with done; high if the command ended by abort
//   step_cnt      out  [STEP_W]  steps issued in the current round
//   round_cnt     out  [ROUND_W] rounds completed
// ---------------------------------------------------------------------------
module updown_sequencer #(
  parameter int STEP_W  = 4,
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [STEP_W-1:0]  cmd_steps,
  input  logic [ROUND_W-1:0] cmd_rounds,
  input  logic               cmd_swap_end,
  input  logic               hold,
  input  logic               abort,
  output logic               enable,
  output logic               swap,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [STEP_W-1:0]  step_cnt,
  output logic [ROUND_W-1:0] round_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SWAP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [STEP_W-1:0]  steps_q, steps_n;
  logic [ROUND_W-1:0] rounds_q, rounds_n;
  logic               swap_end_q, swap_end_n;
  logic [STEP_W-1:0]  step_n;
  logic [ROUND_W-1:0] round_n;
  logic               done_n, aborted_n;

  logic               active;
  logic               last_step;
  logic               end_round;
  logic [ROUND_W-1:0] round_inc;

  // Enable and Swap are combinational so that the counter sees them in the
  // same cycle. The counter samples them on the next edge. Abort takes
  // priority over everything, so an abort cycle never issues a step.
  assign active    = (state_q == S_RUN) || (state_q == S_SWAP);
  assign enable    = active && !hold && !abort;
  assign swap      = (state_q == S_SWAP) && !hold && !abort;
  assign busy      = active;
  assign cmd_ready = (state_q == S_IDLE);

  // The terminal comparisons are made against the current count. This lets a
  // count reach the maximum representable value without wrapping.
  assign last_step = (step_cnt == (steps_q - STEP_W'(1)));
  assign round_inc = round_cnt + ROUND_W'(1);

  // Next-state logic. Registers hold by default.
  // done/aborted are computed as "entering DONE". The registered copies are
  // therefore high for exactly the cycle spent in DONE.
  always_comb begin
    state_n    = state_q;
    steps_n    = steps_q;
    rounds_n   = rounds_q;
    swap_end_n = swap_end_q;
    step_n     = step_cnt;
    round_n    = round_cnt;
    done_n     = 1'b0;
    aborted_n  = 1'b0;
    end_round  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          steps_n    = cmd_steps;
          rounds_n   = cmd_rounds;
          swap_end_n = cmd_swap_end;
          step_n     = '0;
          round_n    = '0;
          // An empty command finishes at once and never raises Enable.
          if ((cmd_steps == '0) || (cmd_rounds == '0)) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          state_n   = S_DONE;
          done_n    = 1'b1;
          aborted_n = 1'b1;
        end else if (!hold) begin
          step_n = step_cnt + STEP_W'(1);
          if (last_step) begin
            // With a swap ending, step_cnt rests at the full step count
            // during the SWAP cycle. The round boundary then clears it.
            if (swap_end_q) begin
              state_n = S_SWAP;
            end else begin
              end_round = 1'b1;
            end
          end
        end
      end

      S_SWAP: begin
        if (abort) begin
          state_n   = S_DONE;
          done_n    = 1'b1;
          aborted_n = 1'b1;
        end else if (!hold) begin
          end_round = 1'b1;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Round boundary is shared by the RUN (no swap) and SWAP exits.
    if (end_round) begin
      round_n = round_inc;
      step_n  = '0;
      if (round_inc == rounds_q) begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end else begin
        state_n = S_RUN;
      end
    end
  end

  // State and datapath registers. Reset discards any in-flight command, so
  // no done pulse follows a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      steps_q    <= '0;
      rounds_q   <= '0;
      swap_end_q <= 1'b0;
      step_cnt   <= '0;
      round_cnt  <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state_q    <= state_n;
      steps_q    <= steps_n;
      rounds_q   <= rounds_n;
      swap_end_q <= swap_end_n;
      step_cnt   <= step_n;
      round_cnt  <= round_n;
      done       <= done_n;
      aborted    <= aborted_n;
    end
  end

endmodule
